// File: rtl/upload_server.sv
// upload_server
//   Services HPS upload (save) reads of core work RAM over the ioctl bus.
//   It pauses the game CPU for the session, inserts wait states to cover
//   the registered RAM's one-cycle read latency, and returns a fill byte
//   for offsets beyond the save window.
//
// Ports
//   clk_sys          system clock
//   reset_n          asynchronous active-low reset
//   save_req         one-cycle pulse: core asks HPS to start an upload
//   ioctl_upload_req request to HPS, held until ioctl_upload rises
//   ioctl_upload     HPS upload session active
//   ioctl_rd         one-cycle read strobe, ioctl_addr valid same cycle
//   ioctl_addr       byte offset in save window
//   ioctl_din        read data to HPS
//   ioctl_wait       high while ioctl_din is not yet valid
//   pause_cpu        CPU pause request
//   paused           CPU pause acknowledge
//   ram_addr         work-RAM address
//   ram_rd           work-RAM read enable
//   ram_data         work-RAM data, valid one cycle after ram_rd
//   busy             high whenever the FSM is not idle
module upload_server #(
  parameter int                ADDR_W = 16,
  parameter logic [ADDR_W-1:0] BASE   = ADDR_W'(16'h6000),
  parameter int                LEN    = 256,
  parameter logic [7:0]        FILL   = 8'hFF
) (
  input  logic              clk_sys,
  input  logic              reset_n,
  input  logic              save_req,
  output logic              ioctl_upload_req,
  input  logic              ioctl_upload,
  input  logic              ioctl_rd,
  input  logic [24:0]       ioctl_addr,
  output logic [7:0]        ioctl_din,
  output logic              ioctl_wait,
  output logic              pause_cpu,
  input  logic              paused,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_rd,
  input  logic [7:0]        ram_data,
  output logic              busy
);

  typedef enum logic [2:0] {
    IDLE, REQ, PAUSE, READY, FETCH, LATCH, DONE
  } state_t;

  // One extra bit so LEN = 2^25 still compares correctly.
  localparam logic [25:0] LEN_W = 26'(LEN);

  state_t            state_q;
  logic              req_q;
  logic [7:0]        din_q;
  logic              wait_q;
  logic              pause_q;
  logic [ADDR_W-1:0] ramAddr_q;
  logic              ramRd_q;
  logic              busy_q;
  logic              pending_q;
  logic [24:0]       pendAddr_q;
  logic              uploadPrev_q;
  logic              endSeen_q;

  logic [24:0]       selAddr_d;
  logic              inWindow_d;

  // A read latched while waiting for the pause acknowledge takes priority
  // over the live strobe; the HPS holds off while ioctl_wait is high.
  always_comb begin
    selAddr_d  = pending_q ? pendAddr_q : ioctl_addr;
    inWindow_d = ({1'b0, selAddr_d} < LEN_W);
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      req_q        <= 1'b0;
      din_q        <= 8'h00;
      wait_q       <= 1'b0;
      pause_q      <= 1'b0;
      ramAddr_q    <= '0;
      ramRd_q      <= 1'b0;
      busy_q       <= 1'b0;
      pending_q    <= 1'b0;
      pendAddr_q   <= '0;
      uploadPrev_q <= 1'b0;
      endSeen_q    <= 1'b0;
    end else begin
      uploadPrev_q <= ioctl_upload;
      case (state_q)
        IDLE: begin
          if (save_req) begin
            state_q <= REQ;
            req_q   <= 1'b1;
            busy_q  <= 1'b1;
          end else if (ioctl_upload && !uploadPrev_q) begin
            // HPS started an upload on its own.
            state_q <= PAUSE;
            pause_q <= 1'b1;
            busy_q  <= 1'b1;
          end
        end
        REQ: begin
          if (ioctl_upload) begin
            state_q <= PAUSE;
            req_q   <= 1'b0;
            pause_q <= 1'b1;
          end
        end
        PAUSE: begin
          // An aborted session must not leave the CPU paused forever.
          if (!ioctl_upload) begin
            state_q   <= DONE;
            wait_q    <= 1'b0;
            pending_q <= 1'b0;
          end else begin
            if (ioctl_rd) begin
              pending_q  <= 1'b1;
              pendAddr_q <= ioctl_addr;
              wait_q     <= 1'b1;
            end
            if (paused) state_q <= READY;
          end
        end
        READY: begin
          if (!ioctl_upload) begin
            state_q   <= DONE;
            wait_q    <= 1'b0;
            pending_q <= 1'b0;
          end else if (pending_q || ioctl_rd) begin
            pending_q <= 1'b0;
            if (inWindow_d) begin
              ramAddr_q <= BASE + selAddr_d[ADDR_W-1:0];
              ramRd_q   <= 1'b1;
              wait_q    <= 1'b1;
              endSeen_q <= 1'b0;
              state_q   <= FETCH;
            end else begin
              din_q  <= FILL;
              wait_q <= 1'b0;
            end
          end
        end
        FETCH: begin
          // Remember a session end seen here so the read finishes first.
          ramRd_q   <= 1'b0;
          endSeen_q <= !ioctl_upload;
          state_q   <= LATCH;
        end
        LATCH: begin
          din_q   <= ram_data;
          wait_q  <= 1'b0;
          state_q <= (!ioctl_upload || endSeen_q) ? DONE : READY;
        end
        DONE: begin
          pause_q <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign ioctl_upload_req = req_q;
  assign ioctl_din        = din_q;
  assign ioctl_wait       = wait_q;
  assign pause_cpu        = pause_q;
  assign ram_addr         = ramAddr_q;
  assign ram_rd           = ramRd_q;
  assign busy             = busy_q;

endmodule

// File: tb/tb_upload_server.sv
// tb_upload_server
//   Directed bench for upload_server: core- and HPS-initiated sessions,
//   in-window and fill reads, early read before pause acknowledge, session
//   end during a fetch, and asynchronous reset mid-read.
module tb_upload_server;

  logic        clk_sys;
  logic        reset_n;
  logic        save_req;
  logic        ioctl_upload_req;
  logic        ioctl_upload;
  logic        ioctl_rd;
  logic [24:0] ioctl_addr;
  logic [7:0]  ioctl_din;
  logic        ioctl_wait;
  logic        pause_cpu;
  logic        paused;
  logic [15:0] ram_addr;
  logic        ram_rd;
  logic [7:0]  ram_data;
  logic        busy;

  int total;
  int bad;

  logic [7:0] mem [0:65535];

  upload_server #(
    .ADDR_W(16),
    .BASE  (16'h6000),
    .LEN   (256),
    .FILL  (8'hFF)
  ) dut (
    .clk_sys         (clk_sys),
    .reset_n         (reset_n),
    .save_req        (save_req),
    .ioctl_upload_req(ioctl_upload_req),
    .ioctl_upload    (ioctl_upload),
    .ioctl_rd        (ioctl_rd),
    .ioctl_addr      (ioctl_addr),
    .ioctl_din       (ioctl_din),
    .ioctl_wait      (ioctl_wait),
    .pause_cpu       (pause_cpu),
    .paused          (paused),
    .ram_addr        (ram_addr),
    .ram_rd          (ram_rd),
    .ram_data        (ram_data),
    .busy            (busy)
  );

  // 100 MHz system clock
  initial clk_sys = 1'b0;
  always #5 clk_sys = ~clk_sys;

  // Registered work RAM: data valid the cycle after ram_rd
  always @(posedge clk_sys) begin
    if (ram_rd) ram_data <= mem[ram_addr];
  end

  // Advance one clock and settle just past the edge
  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  // Drive the HPS/core side inputs for the coming cycle
  task automatic applyStimulus(input logic sr, input logic up, input logic rd,
                               input logic [24:0] addr, input logic pa);
    save_req     = sr;
    ioctl_upload = up;
    ioctl_rd     = rd;
    ioctl_addr   = addr;
    paused       = pa;
  endtask

  // Compare one observed value against its hand-computed expectation
  task automatic checkOutput(input string tag, input logic [31:0] obs,
                             input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Check every output against an all-quiet state
  task automatic checkAllZero(input string tag);
    checkOutput({tag, ".req"},   32'(ioctl_upload_req), 32'h0);
    checkOutput({tag, ".din"},   32'(ioctl_din),        32'h0);
    checkOutput({tag, ".wait"},  32'(ioctl_wait),       32'h0);
    checkOutput({tag, ".pause"}, 32'(pause_cpu),        32'h0);
    checkOutput({tag, ".raddr"}, 32'(ram_addr),         32'h0);
    checkOutput({tag, ".rrd"},   32'(ram_rd),           32'h0);
    checkOutput({tag, ".busy"},  32'(busy),             32'h0);
  endtask

  // Directed sequence
  initial begin
    total = 0;
    bad   = 0;
    for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
    mem[16'h6000] = 8'h3C;
    mem[16'h6001] = 8'h11;
    mem[16'h6005] = 8'hA7;
    mem[16'h60FF] = 8'h5A;
    ram_data = 8'h00;

    reset_n = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b0, 25'd0, 1'b0);
    tick(); tick();
    checkAllZero("reset");
    reset_n = 1'b1;
    tick();

    // Core-initiated save
    applyStimulus(1'b1, 1'b0, 1'b0, 25'd0, 1'b0);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b0, 25'd0, 1'b0);
    checkOutput("save.req", 32'(ioctl_upload_req), 32'h1);
    checkOutput("save.busy", 32'(busy), 32'h1);
    checkOutput("save.pause", 32'(pause_cpu), 32'h0);
    tick();
    checkOutput("req.hold", 32'(ioctl_upload_req), 32'h1);
    applyStimulus(1'b0, 1'b1, 1'b0, 25'd0, 1'b0);
    tick();
    checkOutput("pause.req", 32'(ioctl_upload_req), 32'h0);
    checkOutput("pause.pause", 32'(pause_cpu), 32'h1);
    applyStimulus(1'b0, 1'b1, 1'b0, 25'd0, 1'b1);
    tick();
    checkOutput("ready.wait", 32'(ioctl_wait), 32'h0);

    // In-window read at offset 5
    applyStimulus(1'b0, 1'b1, 1'b1, 25'd5, 1'b1);
    tick();
    applyStimulus(1'b0, 1'b1, 1'b0, 25'd0, 1'b1);
    checkOutput("rd5.t1.rrd", 32'(ram_rd), 32'h1);
    checkOutput("rd5.t1.raddr", 32'(ram_addr), 32'h6005);
    checkOutput("rd5.t1.wait", 32'(ioctl_wait), 32'h1);
    tick();
    checkOutput("rd5.t2.rrd", 32'(ram_rd), 32'h0);
    checkOutput("rd5.t2.wait", 32'(ioctl_wait), 32'h1);
    tick();
    checkOutput("rd5.t3.din", 32'(ioctl_din), 32'hA7);
    checkOutput("rd5.t3.wait", 32'(ioctl_wait), 32'h0);

    // Fill read at offset LEN
    applyStimulus(1'b0, 1'b1, 1'b1, 25'd256, 1'b1);
    tick();
    applyStimulus(1'b0, 1'b1, 1'b0, 25'd0, 1'b1);
    checkOutput("fill.din", 32'(ioctl_din), 32'hFF);
    checkOutput("fill.wait", 32'(ioctl_wait), 32'h0);
    checkOutput("fill.rrd", 32'(ram_rd), 32'h0);
    tick();
    checkOutput("fill.rrd2", 32'(ram_rd), 32'h0);

    // Last in-window offset
    applyStimulus(1'b0, 1'b1, 1'b1, 25'd255, 1'b1);
    tick();
    applyStimulus(1'b0, 1'b1, 1'b0, 25'd0, 1'b1);
    checkOutput("rd255.raddr", 32'(ram_addr), 32'h60FF);
    tick(); tick();
    checkOutput("rd255.din", 32'(ioctl_din), 32'h5A);

    // HPS ends the session from READY
    applyStimulus(1'b0, 1'b0, 1'b0, 25'd0, 1'b1);
    tick();
    checkOutput("done.pause", 32'(pause_cpu), 32'h1);
    checkOutput("done.busy", 32'(busy), 32'h1);
    applyStimulus(1'b0, 1'b0, 1'b0, 25'd0, 1'b0);
    tick();
    checkOutput("idle.pause", 32'(pause_cpu), 32'h0);
    checkOutput("idle.busy", 32'(busy), 32'h0);

    // HPS-initiated session with an early read before pause acknowledge
    applyStimulus(1'b0, 1'b1, 1'b0, 25'd0, 1'b0);
    tick();
    checkOutput("hps.pause", 32'(pause_cpu), 32'h1);
    checkOutput("hps.req", 32'(ioctl_upload_req), 32'h0);
    applyStimulus(1'b0, 1'b1, 1'b1, 25'd0, 1'b0);
    tick();
    applyStimulus(1'b0, 1'b1, 1'b0, 25'd0, 1'b0);
    checkOutput("early.wait", 32'(ioctl_wait), 32'h1);
    for (int i = 0; i < 9; i++) tick();
    checkOutput("early.hold.wait", 32'(ioctl_wait), 32'h1);
    checkOutput("early.hold.rrd", 32'(ram_rd), 32'h0);
    applyStimulus(1'b0, 1'b1, 1'b0, 25'd0, 1'b1);
    tick();
    checkOutput("early.r0.wait", 32'(ioctl_wait), 32'h1);
    tick();
    checkOutput("early.r1.rrd", 32'(ram_rd), 32'h1);
    checkOutput("early.r1.raddr", 32'(ram_addr), 32'h6000);
    tick(); tick();
    checkOutput("early.r3.din", 32'(ioctl_din), 32'h3C);
    checkOutput("early.r3.wait", 32'(ioctl_wait), 32'h0);

    // Session ends during the FETCH cycle of a read
    applyStimulus(1'b0, 1'b1, 1'b1, 25'd1, 1'b1);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b0, 25'd0, 1'b1);
    checkOutput("endf.rrd", 32'(ram_rd), 32'h1);
    tick();
    tick();
    checkOutput("endf.din", 32'(ioctl_din), 32'h11);
    checkOutput("endf.wait", 32'(ioctl_wait), 32'h0);
    checkOutput("endf.pause", 32'(pause_cpu), 32'h1);
    tick();
    checkOutput("endf.idle.pause", 32'(pause_cpu), 32'h0);
    checkOutput("endf.idle.busy", 32'(busy), 32'h0);

    // Asynchronous reset in LATCH
    applyStimulus(1'b1, 1'b0, 1'b0, 25'd0, 1'b1);
    tick();
    applyStimulus(1'b0, 1'b1, 1'b0, 25'd0, 1'b1);
    tick();
    tick();
    applyStimulus(1'b0, 1'b1, 1'b1, 25'd5, 1'b1);
    tick();
    applyStimulus(1'b0, 1'b1, 1'b0, 25'd0, 1'b1);
    checkOutput("rst.fetch.rrd", 32'(ram_rd), 32'h1);
    tick();
    #1;
    reset_n = 1'b0;
    #1;
    checkAllZero("rstmid");
    applyStimulus(1'b0, 1'b0, 1'b0, 25'd0, 1'b0);
    tick();
    reset_n = 1'b1;
    tick();
    applyStimulus(1'b1, 1'b0, 1'b0, 25'd0, 1'b0);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b0, 25'd0, 1'b0);
    checkOutput("restart.req", 32'(ioctl_upload_req), 32'h1);
    checkOutput("restart.busy", 32'(busy), 32'h1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
